// File: rtl/bitonic_sort_ctrl.sv
// Serial-in / serial-out wrapper around a pipelined bitonic sort network.
// Gathers one padded block, issues it to the sorter, and drains only the real elements.
module bitonic_sort_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int LOG_INPUT  = 2,
    parameter bit ASCENDING  = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [DATA_WIDTH-1:0]                   s_data,
    input  logic                                    s_valid,
    input  logic                                    s_last,
    output logic                                    s_ready,
    output logic [DATA_WIDTH-1:0]                   m_data,
    output logic                                    m_valid,
    output logic                                    m_last,
    input  logic                                    m_ready,
    output logic [0:DATA_WIDTH*(2**LOG_INPUT)-1]    sort_x,
    output logic                                    sort_x_valid,
    input  logic [0:DATA_WIDTH*(2**LOG_INPUT)-1]    sort_y,
    input  logic                                    sort_y_valid,
    output logic                                    busy,
    output logic                                    err_spurious
);

    localparam int N  = 2**LOG_INPUT;
    localparam int CW = LOG_INPUT + 1;
    localparam int BW = DATA_WIDTH * N;
    // Pads sort to the tail in either direction, so the head holds every real element.
    localparam logic [DATA_WIDTH-1:0] PAD = {DATA_WIDTH{ASCENDING}};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [CW-1:0]           blk_cnt_reg;
    logic [LOG_INPUT-1:0]    idx_reg;
    logic [0:BW-1]           in_buf_reg;
    logic [0:BW-1]           out_buf_reg;
    logic [0:BW-1]           sort_x_reg;
    logic                    sort_x_valid_reg;
    logic                    s_ready_reg;
    logic                    m_valid_reg;
    logic                    m_last_reg;
    logic [DATA_WIDTH-1:0]   m_data_reg;
    logic                    busy_reg;
    logic                    err_reg;

    logic                    accept;
    logic                    blk_done;
    logic [0:BW-1]           in_buf_next;
    logic [DATA_WIDTH-1:0]   out_elem [N];
    logic [LOG_INPUT-1:0]    idx_inc;
    logic                    last_inc;
    logic                    y_stray;

    assign accept   = s_valid & s_ready_reg;
    assign blk_done = s_last | (cnt_reg == CW'(N - 1));
    assign idx_inc  = idx_reg + 1'b1;
    assign last_inc = (({1'b0, idx_inc} + CW'(1)) == blk_cnt_reg);
    assign y_stray  = sort_y_valid & ((state_reg == ST_LOAD) | (state_reg == ST_DRAIN));

    // Per-slot next value: the accepted element lands in slot cnt, and when the
    // block closes every higher slot is padded in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            localparam logic [CW-1:0] SLOT = CW'(gi);
            logic [DATA_WIDTH-1:0] slot_next;

            always_comb begin
                slot_next = in_buf_reg[gi*DATA_WIDTH +: DATA_WIDTH];
                if (accept) begin
                    if (cnt_reg == SLOT) begin
                        slot_next = s_data;
                    end else if (blk_done && (cnt_reg < SLOT)) begin
                        slot_next = PAD;
                    end
                end
            end

            assign in_buf_next[gi*DATA_WIDTH +: DATA_WIDTH] = slot_next;
            assign out_elem[gi] = out_buf_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_LOAD;
            cnt_reg          <= '0;
            blk_cnt_reg      <= '0;
            idx_reg          <= '0;
            in_buf_reg       <= '0;
            out_buf_reg      <= '0;
            sort_x_reg       <= '0;
            sort_x_valid_reg <= 1'b0;
            s_ready_reg      <= 1'b0;
            m_valid_reg      <= 1'b0;
            m_last_reg       <= 1'b0;
            m_data_reg       <= '0;
            busy_reg         <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            sort_x_valid_reg <= 1'b0;
            if (y_stray) begin
                err_reg <= 1'b1;
            end

            case (state_reg)
                ST_LOAD: begin
                    // Also raises s_ready on the first cycle out of reset.
                    s_ready_reg <= 1'b1;
                    if (accept) begin
                        in_buf_reg <= in_buf_next;
                        cnt_reg    <= cnt_reg + 1'b1;
                        busy_reg   <= 1'b1;
                        if (blk_done) begin
                            blk_cnt_reg      <= cnt_reg + 1'b1;
                            sort_x_reg       <= in_buf_next;
                            sort_x_valid_reg <= 1'b1;
                            s_ready_reg      <= 1'b0;
                            state_reg        <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE, ST_WAIT: begin
                    // Capture is allowed in ISSUE so a zero-latency sorter works.
                    if (sort_y_valid) begin
                        out_buf_reg <= sort_y;
                        idx_reg     <= '0;
                        m_valid_reg <= 1'b1;
                        m_data_reg  <= sort_y[0 +: DATA_WIDTH];
                        m_last_reg  <= (blk_cnt_reg == CW'(1));
                        state_reg   <= ST_DRAIN;
                    end else begin
                        state_reg   <= ST_WAIT;
                    end
                end

                ST_DRAIN: begin
                    if (m_ready) begin
                        if (m_last_reg) begin
                            m_valid_reg <= 1'b0;
                            m_last_reg  <= 1'b0;
                            m_data_reg  <= '0;
                            cnt_reg     <= '0;
                            busy_reg    <= 1'b0;
                            s_ready_reg <= 1'b1;
                            state_reg   <= ST_LOAD;
                        end else begin
                            idx_reg    <= idx_inc;
                            m_data_reg <= out_elem[idx_inc];
                            m_last_reg <= last_inc;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_LOAD;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_reg;
    assign m_data       = m_data_reg;
    assign m_valid      = m_valid_reg;
    assign m_last       = m_last_reg;
    assign sort_x       = sort_x_reg;
    assign sort_x_valid = sort_x_valid_reg;
    assign busy         = busy_reg;
    assign err_spurious = err_reg;

endmodule
